// File: rtl/synapse_accumulator.sv
// ---------------------------------------------------------------------------
// synapse_accumulator
//
// Per-timestep synaptic current integrator for the LIF neuron stage.
// A timestep start latches the presynaptic spike vector. The block then walks
// the synapses one per cycle and adds the programmed weight of every active
// synapse into a saturating accumulator. The result is presented as a single
// registered one-cycle current pulse. The current is zero in every other
// cycle, so the neuron can add it unconditionally each cycle and still
// integrate each timestep exactly once.
//
// Parameters:
//   DATA_LENGTH  width of the output current (neuron data width)
//   NUM_SYN      number of presynaptic inputs (>= 2)
//   WEIGHT_W     unsigned weight width (<= DATA_LENGTH)
//   ADDR_W       weight address width
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            synchronous active-high reset
//   i_step_start     timestep start request, honoured only when idle
//   i_pre_spikes     presynaptic spike bits, latched with an accepted start
//   i_w_we           weight write enable (legal in any state)
//   i_w_addr         weight index; indices >= NUM_SYN are ignored
//   i_w_data         unsigned weight value
//   o_current        registered synaptic current, zero outside the pulse
//   o_current_valid  one-cycle pulse marking the result
//   o_sat            pulses with o_current_valid if the sum clamped
//   o_busy           high while synapses are being accumulated
// ---------------------------------------------------------------------------
module synapse_accumulator #(
    parameter int DATA_LENGTH = 32,
    parameter int NUM_SYN     = 8,
    parameter int WEIGHT_W    = 16,
    parameter int ADDR_W      = $clog2(NUM_SYN)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_step_start,
    input  logic [NUM_SYN-1:0]     i_pre_spikes,
    input  logic                   i_w_we,
    input  logic [ADDR_W-1:0]      i_w_addr,
    input  logic [WEIGHT_W-1:0]    i_w_data,
    output logic [DATA_LENGTH-1:0] o_current,
    output logic                   o_current_valid,
    output logic                   o_sat,
    output logic                   o_busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0]      LAST_IDX    = ADDR_W'(NUM_SYN - 1);
    localparam logic [DATA_LENGTH-1:0] MAX_CURRENT = '1;

    state_t                 state;
    state_t                 state_next;

    logic [WEIGHT_W-1:0]    weights [NUM_SYN];
    logic [NUM_SYN-1:0]     spk;
    logic [ADDR_W-1:0]      idx;
    logic [DATA_LENGTH-1:0] acc;
    logic                   sat_sticky;

    logic [DATA_LENGTH-1:0] term;
    logic [DATA_LENGTH:0]   sum_wide;
    logic                   clamp_now;
    logic [DATA_LENGTH-1:0] sum_sat;
    logic                   last_syn;

    // -----------------------------------------------------------------------
    // Weight bank. Each register compares the write address against its own
    // index, so an out-of-range address simply matches nothing. A same-cycle
    // read of the entry being written sees the old contents, because the
    // datapath reads the registered value.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                weights[i] <= '0;
            end
        end else if (i_w_we) begin
            for (int i = 0; i < NUM_SYN; i++) begin
                if (i_w_addr == ADDR_W'(i)) begin
                    weights[i] <= i_w_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Saturating add of the current synapse's contribution. The sum is one
    // bit wider than the accumulator, and its carry bit is the clamp
    // indicator. Once the accumulator sits at max, further nonzero terms
    // clamp again, so it stays pinned for the rest of the step.
    // -----------------------------------------------------------------------
    always_comb begin
        term = '0;
        if (spk[idx]) begin
            term = DATA_LENGTH'(weights[idx]);
        end
        sum_wide  = {1'b0, acc} + {1'b0, term};
        clamp_now = sum_wide[DATA_LENGTH];
        sum_sat   = clamp_now ? MAX_CURRENT : sum_wide[DATA_LENGTH-1:0];
    end

    assign last_syn = (state == ACCUM) && (idx == LAST_IDX);

    // -----------------------------------------------------------------------
    // FSM state register.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic. A start request seen while accumulating is
    // dropped rather than queued. The step returns to IDLE on the last
    // synapse, so the valid cycle is already idle and can accept a new start.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_step_start) begin
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        o_busy = (state == ACCUM);
    end

    // -----------------------------------------------------------------------
    // Step datapath. The spike vector is captured once at the start, so input
    // changes during the step are invisible. On the last synapse, the
    // accumulator is not updated: the final sum goes straight to the output
    // register, and the next start clears everything anyway.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            spk        <= '0;
            idx        <= '0;
            acc        <= '0;
            sat_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_step_start) begin
                        spk        <= i_pre_spikes;
                        idx        <= '0;
                        acc        <= '0;
                        sat_sticky <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (last_syn) begin
                        idx <= '0;
                    end else begin
                        idx        <= idx + 1'b1;
                        acc        <= sum_sat;
                        sat_sticky <= sat_sticky | clamp_now;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Registered result pulse. Every cycle except the one after the last
    // synapse drives zeros. This lets the neuron add o_current without
    // gating it by o_current_valid.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_current       <= '0;
            o_current_valid <= 1'b0;
            o_sat           <= 1'b0;
        end else if (last_syn) begin
            o_current       <= sum_sat;
            o_current_valid <= 1'b1;
            o_sat           <= sat_sticky | clamp_now;
        end else begin
            o_current       <= '0;
            o_current_valid <= 1'b0;
            o_sat           <= 1'b0;
        end
    end

    // The result is a strict single-cycle pulse, and nothing leaks outside it.
    pulse_single : assert property (@(posedge i_clk) disable iff (i_rst)
        o_current_valid |=> !o_current_valid);

    quiet_outside_pulse : assert property (@(posedge i_clk) disable iff (i_rst)
        !o_current_valid |-> (o_current == '0 && !o_sat));

    idle_during_pulse : assert property (@(posedge i_clk) disable iff (i_rst)
        o_current_valid |-> !o_busy);

endmodule

// File: tb/tb_synapse_accumulator.sv
// ---------------------------------------------------------------------------
// tb_synapse_accumulator
//
// Scoreboard bench for synapse_accumulator. It uses a 16-bit current so that
// saturation is reachable. Each launched step pushes its expected current,
// saturation flag and due cycle. A negedge monitor pops and compares every
// valid pulse and checks that the outputs are quiet in all other cycles.
// ---------------------------------------------------------------------------
module tb_synapse_accumulator;

    localparam int     DATA_LENGTH = 16;
    localparam int     NUM_SYN     = 8;
    localparam int     WEIGHT_W    = 16;
    localparam int     ADDR_W      = $clog2(NUM_SYN);
    localparam longint MAX_CURRENT = (longint'(1) << DATA_LENGTH) - 1;

    logic                   clk;
    logic                   rst;
    logic                   step_start;
    logic [NUM_SYN-1:0]     pre_spikes;
    logic                   w_we;
    logic [ADDR_W-1:0]      w_addr;
    logic [WEIGHT_W-1:0]    w_data;
    logic [DATA_LENGTH-1:0] current;
    logic                   current_valid;
    logic                   sat;
    logic                   busy;

    typedef struct {
        longint cur;
        bit     sat;
        int     due;
    } exp_t;

    exp_t   sb_q[$];
    longint wmodel[NUM_SYN];
    int     cyc;
    int     total;
    int     bad;
    longint exp_cur;
    bit     exp_sat;

    synapse_accumulator #(
        .DATA_LENGTH(DATA_LENGTH),
        .NUM_SYN    (NUM_SYN),
        .WEIGHT_W   (WEIGHT_W),
        .ADDR_W     (ADDR_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_step_start   (step_start),
        .i_pre_spikes   (pre_spikes),
        .i_w_we         (w_we),
        .i_w_addr       (w_addr),
        .i_w_data       (w_data),
        .o_current      (current),
        .o_current_valid(current_valid),
        .o_sat          (sat),
        .o_busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Reference step result from the bench's own weight model. ovr_idx lets
    // a caller substitute one weight that the step is known to pick up.
    function automatic void modelStep(input logic [NUM_SYN-1:0] spikes, input int ovr_idx,
                                      input longint ovr_val, output longint cur, output bit clamped);
        longint sum_all;
        sum_all = 0;
        for (int i = 0; i < NUM_SYN; i++) begin
            if (spikes[i]) begin
                sum_all += (i == ovr_idx) ? ovr_val : wmodel[i];
            end
        end
        clamped = (sum_all > MAX_CURRENT);
        cur     = clamped ? MAX_CURRENT : sum_all;
    endfunction

    task automatic writeWeight(input int addr, input longint value);
        w_we   = 1'b1;
        w_addr = ADDR_W'(addr);
        w_data = WEIGHT_W'(value);
        @(negedge clk);
        w_we   = 1'b0;
        wmodel[addr] = value;
    endtask

    // Launches a step from IDLE and records its expected result. After the
    // start edge, it scrambles the spike inputs, which the step must ignore.
    task automatic applyStimulus(input logic [NUM_SYN-1:0] spikes, input longint cur, input bit clamped);
        exp_t e;
        pre_spikes = spikes;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        pre_spikes = ~spikes;
        e.cur = cur;
        e.sat = clamped;
        e.due = cyc + NUM_SYN;
        sb_q.push_back(e);
    endtask

    // Runs out a launched step while checking busy. It can re-pulse start
    // mid-step, and it ends one cycle after the valid cycle.
    task automatic waitStep(input int restart_at);
        for (int k = 0; k < NUM_SYN; k++) begin
            checkOutput("busy", longint'(busy), 1);
            step_start = (k == restart_at);
            @(negedge clk);
        end
        step_start = 1'b0;
        checkOutput("busy_after", longint'(busy), 0);
        @(negedge clk);
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (current_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_valid", longint'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                checkOutput("current", longint'(current), e.cur);
                checkOutput("sat", longint'(sat), longint'(e.sat));
                checkOutput("latency", longint'(cyc), longint'(e.due));
            end
        end else begin
            checkOutput("idle_current", longint'(current), 0);
            checkOutput("idle_sat", longint'(sat), 0);
            if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
                checkOutput("missed_valid", longint'(current_valid), 1);
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        step_start = 1'b0;
        pre_spikes = '0;
        w_we       = 1'b0;
        w_addr     = '0;
        w_data     = '0;
        for (int i = 0; i < NUM_SYN; i++) wmodel[i] = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_current", longint'(current), 0);
        checkOutput("rst_valid", longint'(current_valid), 0);
        checkOutput("rst_sat", longint'(sat), 0);
        checkOutput("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic sums.
        for (int i = 0; i < NUM_SYN; i++) writeWeight(i, 10 * (i + 1));
        modelStep(8'b1010_0101, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'b1010_0101, exp_cur, exp_sat);
        waitStep(-1);
        modelStep(8'b0100_1011, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'b0100_1011, exp_cur, exp_sat);
        waitStep(-1);

        // A start re-pulsed in the third cycle of a step is dropped.
        modelStep(8'b1111_0000, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'b1111_0000, exp_cur, exp_sat);
        waitStep(2);
        repeat (NUM_SYN + 2) @(negedge clk);

        // A start in the valid cycle is accepted, back to back.
        modelStep(8'b0000_1111, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'b0000_1111, exp_cur, exp_sat);
        repeat (NUM_SYN) @(negedge clk);
        checkOutput("b2b_valid_idle", longint'(busy), 0);
        modelStep(8'b1100_0011, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'b1100_0011, exp_cur, exp_sat);
        waitStep(-1);

        // Weight writes racing the scan:
        //   index 6 is written at E3 (ahead of the scan, so the new value is used);
        //   index 1 is written at E4 (already passed, so it has no effect);
        //   index 4 is written at E5 (being read that cycle, so the old value is used).
        modelStep(8'hFF, 6, 1000, exp_cur, exp_sat);
        applyStimulus(8'hFF, exp_cur, exp_sat);
        for (int k = 0; k < NUM_SYN; k++) begin
            checkOutput("race_busy", longint'(busy), 1);
            case (k)
                2: begin w_we = 1'b1; w_addr = 3'd6; w_data = 16'd1000; end
                3: begin w_we = 1'b1; w_addr = 3'd1; w_data = 16'd500;  end
                4: begin w_we = 1'b1; w_addr = 3'd4; w_data = 16'd700;  end
                default: w_we = 1'b0;
            endcase
            @(negedge clk);
        end
        w_we = 1'b0;
        @(negedge clk);
        wmodel[6] = 1000;
        wmodel[1] = 500;
        wmodel[4] = 700;
        modelStep(8'hFF, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'hFF, exp_cur, exp_sat);
        waitStep(-1);

        // Saturation: exact max without a clamp, a full clamp, then a
        // no-spike step that must not inherit the clamp flag.
        for (int i = 0; i < NUM_SYN; i++) writeWeight(i, 16'hFFFF);
        modelStep(8'h01, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'h01, exp_cur, exp_sat);
        waitStep(-1);
        modelStep(8'hFF, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'hFF, exp_cur, exp_sat);
        waitStep(-1);
        modelStep(8'h00, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'h00, exp_cur, exp_sat);
        waitStep(-1);

        // Reset in the fourth ACCUM cycle aborts the step and clears the weights.
        pre_spikes = 8'hFF;
        step_start = 1'b1;
        @(negedge clk);
        step_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_SYN; i++) wmodel[i] = 0;
        checkOutput("midrst_busy", longint'(busy), 0);
        checkOutput("midrst_valid", longint'(current_valid), 0);
        repeat (NUM_SYN + 2) @(negedge clk);
        modelStep(8'hFF, -1, 0, exp_cur, exp_sat);
        applyStimulus(8'hFF, exp_cur, exp_sat);
        waitStep(-1);

        repeat (2) @(negedge clk);
        checkOutput("pending", longint'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/synapse_accumulator.md
# synapse_accumulator

Per-timestep synaptic current integrator feeding the LIF neuron stage's `i_spike` input. When a timestep starts, it latches a vector of presynaptic spike bits and serially sums the programmable weight of every active synapse, one synapse per cycle. It then presents the saturated sum as a single-cycle current pulse that the downstream neuron adds to its membrane state. The output is zero in every other cycle, so the neuron integrates each timestep's current exactly once.

## Interface
- `DATA_LENGTH`, 32: width of the output current; matches the neuron data width.
- `NUM_SYN`, 8: number of presynaptic inputs (≥2).
- `WEIGHT_W`, 16: unsigned weight width (≤ `DATA_LENGTH`).
- `ADDR_W`, `$clog2(NUM_SYN)`: weight address width.

Ports:
- `i_clk`  in  1  clock; all logic on its rising edge.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_step_start`  in  1  timestep start request; sampled only in IDLE.
- `i_pre_spikes`  in  `NUM_SYN`  presynaptic spike bits; latched with an accepted start.
- `i_w_we`  in  1  weight write enable.
- `i_w_addr`  in  `ADDR_W`  weight index; writes with index ≥ `NUM_SYN` are ignored.
- `i_w_data`  in  `WEIGHT_W`  unsigned weight value.
- `o_current`  out  `DATA_LENGTH`  synaptic current; nonzero only while `o_current_valid`=1.
- `o_current_valid`  out  1  one-cycle pulse marking the result.
- `o_sat`  out  1  pulses with `o_current_valid` if the sum clamped.
- `o_busy`  out  1  high in ACCUM.

## Operation
- **Weight bank:** `NUM_SYN` × `WEIGHT_W` registers.
  - A write lands at the edge where `i_w_we`=1.
  - A read in the same cycle as a write to the same index returns the old value.
  - Writes are legal in any state.
- **States:** IDLE and ACCUM.
- **IDLE:**
  - With `i_step_start`=1 at an edge: latch `i_pre_spikes` into `spk`, set `idx`←0, `acc`←0, and go to ACCUM.
  - Otherwise remain in IDLE.
- **ACCUM, each edge:**
  - `term` = `spk[idx]` ? zero-extended `w[idx]` : 0.
  - `acc` ← `sat(acc + term)`; `idx` ← `idx`+1.
- **Last synapse (`idx` = `NUM_SYN`-1):** at that edge, instead of updating `acc`:
  - `o_current` ← `sat(acc + term)`.
  - `o_current_valid` ← 1.
  - `o_sat` ← 1 if any clamp occurred during this step.
  - Return to IDLE.
- **Arithmetic:**
  - The sum is computed `DATA_LENGTH`+1 bits wide.
  - If bit `DATA_LENGTH` is set, the result clamps to 2^`DATA_LENGTH`−1.
  - After a clamp, `acc` stays at max for the rest of the step, and the clamp is recorded in a sticky flag cleared at the start of each step.
- **Pulse clearing:** in every cycle after a valid pulse, `o_current`=0, `o_current_valid`=0, `o_sat`=0.
- **Busy handling:** `i_step_start` during ACCUM is ignored, not queued. Changes to `i_pre_spikes` during ACCUM have no effect.
- **Zero-weight or no-spike step:** still produces `o_current_valid`=1 with `o_current`=0.

## Timing
- **Reset values:** at an edge with `i_rst`=1, all of the following are cleared, and `i_rst` has priority over start and write:
  - state IDLE, `idx`=0, `acc`=0, sticky flag 0;
  - all weights 0;
  - `o_current`=0, `o_current_valid`=0, `o_sat`=0, `o_busy`=0.
- **Mid-step reset:** reset during ACCUM aborts the step, and no valid pulse is produced for it.
- **Latency:** start sampled at edge E0 ⇒ `o_busy`=1 from E0 to E(`NUM_SYN`). `o_current_valid`=1 in the cycle following edge E(`NUM_SYN`), and drops at E(`NUM_SYN`+1).
- **Throughput:** state is IDLE during the valid cycle, so a start sampled at E(`NUM_SYN`+1) is accepted. Back-to-back steps therefore run every `NUM_SYN`+1 cycles.
- **Weight write during ACCUM:**
  - affects the step only if the written index > `idx` at the write edge;
  - a write to the index currently being read uses the old value.
- **Downstream contract:** `o_current` is registered, so the neuron may add it combinationally each cycle.

## Test plan
- **Basic sum:** reset; write weights 0..7 = 10,20,...,80; start with spikes=8'b1010_0101. Expect valid exactly 8 cycles after start, `o_current`=10+30+60+80=180, `o_sat`=0, and `o_current`=0 in the cycles before and after.
- **Saturation:** `DATA_LENGTH`=16, all weights 0xFFFF, spikes=all ones. Expect `o_current`=0xFFFF and `o_sat`=1 on the valid cycle, then `o_sat`=0.
- **Busy and back-to-back:**
  - Pulse start again at cycle 3 of a step: ignored, exactly one valid pulse.
  - Start asserted in the valid cycle: accepted, second valid pulse 9 cycles after the first.
- **Weight write race:**
  - During ACCUM, write index 6 (not yet reached) to 1000 ⇒ the new value is used.
  - Write index 1 (already passed) ⇒ the old value is used.
- **Reset mid-step:** assert `i_rst` in cycle 4 of ACCUM. Expect no valid pulse, `o_busy`=0, and a subsequent step with spikes=all ones giving `o_current`=0 (weights cleared).
